// File: rtl/nios_dbg_pkg.sv
// nios_dbg_pkg: shared types and constants for the Nios II debug system-clock command unit.
//   dbg_state_e     command FSM state (idle / command held for the consumer)
//   IR_*            virtual-JTAG instruction codes decoded into action channels
//   DEFAULT_SR_W    default scan register / jdo width
//   DEFAULT_ACT_BIT default jdo bit that selects action versus no-action
package nios_dbg_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } dbg_state_e;

  localparam int unsigned IR_OCIMEM    = 0;
  localparam int unsigned IR_TRACEMEM  = 1;
  localparam int unsigned IR_BREAK     = 2;
  localparam int unsigned IR_TRACECTRL = 3;

  localparam int unsigned DEFAULT_SR_W    = 38;
  localparam int unsigned DEFAULT_ACT_BIT = 37;

endpackage

// File: rtl/nios_dbg_strobe_sync.sv
// nios_dbg_strobe_sync: brings an asynchronous level strobe into the clk domain and emits a
// registered one-cycle pulse on its rising edge.
//   clk      system clock
//   reset_n  asynchronous active-low reset; clears the synchroniser chain
//   strobe_i asynchronous level input
//   rise_o   one-cycle pulse; a strobe first sampled at edge 0 pulses after edge SYNC_STAGES
module nios_dbg_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   synced_dly_q, synced_dly_d;
  logic                   rise_q, rise_d;

  always_comb begin
    chain_d      = {chain_q[SYNC_STAGES-2:0], strobe_i};
    synced_dly_d = chain_q[SYNC_STAGES-1];
    rise_d       = chain_q[SYNC_STAGES-1] & ~synced_dly_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q      <= '0;
      synced_dly_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      synced_dly_q <= synced_dly_d;
      rise_q       <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/nios_dbg_sysclk_cmd_unit.sv
// nios_dbg_sysclk_cmd_unit: system-clock half of the Nios II JTAG debug slave.
// Synchronises the TCK-domain update-IR/update-DR strobes, latches IR and the scan register
// into jdo, offers the command over valid/ready and then fires one-hot action pulses.
//   clk, reset_n          system clock, asynchronous active-low reset
//   ir_in, sr             TCK-domain IR and scan register (quasi-static around the strobes)
//   vs_uir, vs_udr        asynchronous update-IR / update-DR levels
//   jdo, cmd_ir           latched scan data and the IR that goes with it
//   cmd_valid, cmd_ready  command handshake
//   take_action           one-cycle pulse at index cmd_ir when jdo[ACT_BIT] = 1
//   take_no_action        one-cycle pulse at index cmd_ir when jdo[ACT_BIT] = 0
//   overrun, overrun_clr  sticky flag for a UDR that arrived while a command was pending
//   timeout               sticky handshake-timeout flag
// Build option: define DBG_CMD_TIMEOUT_EN to drop commands left unaccepted for TIMEOUT_CYC
// cycles; without it HOLD waits indefinitely and timeout is tied low.
module nios_dbg_sysclk_cmd_unit
  import nios_dbg_pkg::*;
#(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SR_W        = DEFAULT_SR_W,
  parameter int unsigned N_ACT       = 4,
  parameter int unsigned ACT_BIT     = DEFAULT_ACT_BIT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [SR_W-1:0]  sr,
  input  logic             vs_uir,
  input  logic             vs_udr,
  output logic [SR_W-1:0]  jdo,
  output logic [IR_W-1:0]  cmd_ir,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [N_ACT-1:0] take_action,
  output logic [N_ACT-1:0] take_no_action,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             timeout
);

  logic uir_rise;
  logic udr_rise;

  nios_dbg_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe_i(vs_uir),
    .rise_o  (uir_rise)
  );

  nios_dbg_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe_i(vs_udr),
    .rise_o  (udr_rise)
  );

  dbg_state_e       state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [SR_W-1:0]  jdo_q, jdo_d;
  logic [IR_W-1:0]  cmd_ir_q, cmd_ir_d;
  logic [N_ACT-1:0] act_q, act_d;
  logic [N_ACT-1:0] no_act_q, no_act_d;
  logic             overrun_q, overrun_d;
  logic [N_ACT-1:0] ir_hit;

`ifdef DBG_CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Codes at or above N_ACT leave ir_hit all-zero, so such commands complete silently.
  always_comb begin
    ir_hit = '0;
    for (int unsigned i = 0; i < N_ACT; i++) begin
      if (cmd_ir_q == IR_W'(i)) begin
        ir_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    jdo_d     = jdo_q;
    cmd_ir_d  = cmd_ir_q;
    act_d     = '0;
    no_act_d  = '0;
    overrun_d = overrun_q & ~overrun_clr;
`ifdef DBG_CMD_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q & ~overrun_clr;
`endif

    // Capture below reads the old ir_q, so a coincident UIR only affects later commands.
    if (uir_rise) begin
      ir_d = ir_in;
    end

    unique case (state_q)
      StIdle: begin
        if (udr_rise) begin
          jdo_d    = sr;
          cmd_ir_d = ir_q;
          state_d  = StHold;
`ifdef DBG_CMD_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StHold: begin
        // A UDR while holding is always dropped, even when the handshake lands this cycle.
        if (udr_rise) begin
          overrun_d = 1'b1;
        end
        if (cmd_ready) begin
          state_d = StIdle;
          if (jdo_q[ACT_BIT]) begin
            act_d = ir_hit;
          end else begin
            no_act_d = ir_hit;
          end
        end else begin
`ifdef DBG_CMD_TIMEOUT_EN
          if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      jdo_q     <= '0;
      cmd_ir_q  <= '0;
      act_q     <= '0;
      no_act_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      jdo_q     <= jdo_d;
      cmd_ir_q  <= cmd_ir_d;
      act_q     <= act_d;
      no_act_q  <= no_act_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef DBG_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // TIMEOUT_CYC only sizes the optional counter; both branches tie the flag low here.
  if (TIMEOUT_CYC > 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_no_timeout_zero
    assign timeout = 1'b0;
  end
`endif

  assign jdo            = jdo_q;
  assign cmd_ir         = cmd_ir_q;
  assign cmd_valid      = (state_q == StHold);
  assign take_action    = act_q;
  assign take_no_action = no_act_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_nios_dbg_sysclk_cmd_unit.sv
// tb_nios_dbg_sysclk_cmd_unit: directed and randomized bench for the debug command unit.
// A 2-bit-IR instance carries most checks; a 3-bit-IR instance covers undecoded IR codes and,
// when DBG_CMD_TIMEOUT_EN is defined, a TIMEOUT_CYC=16 instance covers the handshake timeout.
module tb_nios_dbg_sysclk_cmd_unit;
  import nios_dbg_pkg::*;

  localparam int unsigned SR_W    = 38;
  localparam int unsigned ACT_BIT = 37;
  localparam int unsigned N_ACT   = 4;
  localparam int unsigned SYNC    = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_uir, vs_udr, cmd_ready, overrun_clr;

  logic [SR_W-1:0]  jdo;
  logic [1:0]       cmd_ir;
  logic             cmd_valid, overrun, timeout;
  logic [N_ACT-1:0] take_action, take_no_action;

  logic [SR_W-1:0]  jdo3;
  logic [2:0]       cmd_ir3;
  logic             cmd_valid3, overrun3, timeout3;
  logic [N_ACT-1:0] ta3, tn3;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0] m_ir3;  // model: last IR loaded through update-IR

  always #5 clk = ~clk;

  nios_dbg_sysclk_cmd_unit #(
    .IR_W(2), .SR_W(SR_W), .N_ACT(N_ACT), .ACT_BIT(ACT_BIT), .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in[1:0]), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .jdo(jdo), .cmd_ir(cmd_ir), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .take_action(take_action), .take_no_action(take_no_action), .overrun(overrun),
    .overrun_clr(overrun_clr), .timeout(timeout)
  );

  nios_dbg_sysclk_cmd_unit #(
    .IR_W(3), .SR_W(SR_W), .N_ACT(N_ACT), .ACT_BIT(ACT_BIT), .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(1024)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .jdo(jdo3), .cmd_ir(cmd_ir3), .cmd_valid(cmd_valid3),
    .cmd_ready(cmd_ready), .take_action(ta3), .take_no_action(tn3), .overrun(overrun3),
    .overrun_clr(overrun_clr), .timeout(timeout3)
  );

`ifdef DBG_CMD_TIMEOUT_EN
  logic [SR_W-1:0]  jdo_t;
  logic [1:0]       cmd_ir_t;
  logic             cmd_valid_t, overrun_t, timeout_t;
  logic [N_ACT-1:0] ta_t, tn_t;

  nios_dbg_sysclk_cmd_unit #(
    .IR_W(2), .SR_W(SR_W), .N_ACT(N_ACT), .ACT_BIT(ACT_BIT), .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(16)
  ) dut_to (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in[1:0]), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .jdo(jdo_t), .cmd_ir(cmd_ir_t), .cmd_valid(cmd_valid_t),
    .cmd_ready(cmd_ready), .take_action(ta_t), .take_no_action(tn_t), .overrun(overrun_t),
    .overrun_clr(overrun_clr), .timeout(timeout_t)
  );
`endif

  // Reference: an accepted command pulses channel ir on the vector chosen by sr[ACT_BIT],
  // or nothing when ir has no channel.
  function automatic logic [N_ACT-1:0] exp_pulse(input int unsigned ir,
                                                 input logic [SR_W-1:0] v, input bit want_act);
    logic [N_ACT-1:0] r;
    r = '0;
    if (ir < N_ACT && (v[ACT_BIT] == want_act)) r = N_ACT'(1) << ir;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ir(input logic [2:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (6) tick();
    vs_uir = 1'b0;
    repeat (6) tick();
    m_ir3 = v;
  endtask

  // Counts edges from the one that first samples vs_udr to the one that raises cmd_valid.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_valid && n < 12);
  endtask

  task automatic run_cmd(input string tag, input logic [SR_W-1:0] v, input int delay);
    int n, held, extra;
    cmd_ready = 1'b0;
    sr        = v;
    vs_udr    = 1'b1;
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n - 1), 64'(SYNC + 1));
    chk({tag, "_jdo"}, 64'(jdo), 64'(v));
    chk({tag, "_cmd_ir"}, 64'(cmd_ir), 64'(m_ir3[1:0]));
    held  = 1;
    extra = 0;
    repeat (delay) begin
      tick();
      if (cmd_valid) held++;
      if (take_action != 0 || take_no_action != 0) extra++;
    end
    chk({tag, "_held"}, 64'(held), 64'(delay + 1));
    chk({tag, "_early_pulse"}, 64'(extra), 64'd0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_act"}, 64'(take_action), 64'(exp_pulse(m_ir3[1:0], v, 1'b1)));
    chk({tag, "_noact"}, 64'(take_no_action), 64'(exp_pulse(m_ir3[1:0], v, 1'b0)));
    tick();
    chk({tag, "_pulse_end"}, 64'({take_action, take_no_action}), 64'd0);
    vs_udr = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]     r;
    logic [SR_W-1:0] v, held_sr;
    int              n, pulses, held;

    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; overrun_clr = 1'b0; m_ir3 = '0;
    repeat (3) tick();
    chk("reset_outs", 64'({cmd_valid, take_action, take_no_action, overrun, timeout}), 64'd0);
    chk("reset_jdo", 64'({jdo, cmd_ir}), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Directed: action on IR_BREAK with ready already high.
    cmd_ready = 1'b1;
    load_ir(3'(IR_BREAK));
    v = 38'h20_1234_5678;
    sr = v;
    vs_udr = 1'b1;
    wait_valid(n);
    chk("t1_latency", 64'(n - 1), 64'(SYNC + 1));
    chk("t1_jdo", 64'(jdo), 64'(v));
    chk("t1_cmd_ir", 64'(cmd_ir), 64'(IR_BREAK));
    tick();
    chk("t1_act", 64'(take_action), 64'(exp_pulse(IR_BREAK, v, 1'b1)));
    chk("t1_noact", 64'(take_no_action), 64'd0);
    chk("t1_valid_drop", 64'(cmd_valid), 64'd0);
    tick();
    chk("t1_act_end", 64'(take_action), 64'd0);
    repeat (2) tick();
    chk("t1_no_recapture", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0;
    cmd_ready = 1'b0;
    repeat (6) tick();

    // Directed: no-action on IR_OCIMEM with 20 cycles of backpressure.
    load_ir(3'(IR_OCIMEM));
    run_cmd("t2", 38'h0_1234_5678, 19);

    // Randomized commands, IR reloaded about half the time.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(1, 0) == 1) load_ir(3'($urandom_range(7, 0)));
      r = {$urandom(), $urandom()};
      run_cmd($sformatf("rnd%0d", k), r[SR_W-1:0], int'($urandom_range(6, 0)));
    end
    chk("timeout_tied", 64'(timeout), 64'd0);

    // Overrun: second UDR while holding is dropped and flagged.
    r = {$urandom(), $urandom()};
    held_sr = r[SR_W-1:0];
    cmd_ready = 1'b0;
    sr = held_sr;
    vs_udr = 1'b1;
    wait_valid(n);
    vs_udr = 1'b0;
    repeat (6) tick();
    chk("ov_before", 64'(overrun), 64'd0);
    sr = 38'h0_0000_00AA;
    vs_udr = 1'b1;
    repeat (8) tick();
    chk("ov_set", 64'(overrun), 64'd1);
    chk("ov_jdo_kept", 64'(jdo), 64'(held_sr));
    chk("ov_still_valid", 64'(cmd_valid), 64'd1);
    vs_udr = 1'b0;
    repeat (6) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ov_clr", 64'(overrun), 64'd0);
    vs_udr = 1'b1;
    repeat (3) tick();
    overrun_clr = 1'b1;  // coincides with the overrun event of this UDR
    tick();
    overrun_clr = 1'b0;
    chk("ov_set_wins", 64'(overrun), 64'd1);
    tick();
    chk("ov_sticky", 64'(overrun), 64'd1);
    chk("ov_jdo_kept2", 64'(jdo), 64'(held_sr));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("ov_act", 64'(take_action), 64'(exp_pulse(m_ir3[1:0], held_sr, 1'b1)));
    chk("ov_noact", 64'(take_no_action), 64'(exp_pulse(m_ir3[1:0], held_sr, 1'b0)));
    vs_udr = 1'b0;
    repeat (6) tick();

    // Undecoded IR on the 3-bit instance: handshake completes with no pulse.
    load_ir(3'd6);
    v = 38'h20_0000_0F0F;
    cmd_ready = 1'b1;
    sr = v;
    vs_udr = 1'b1;
    wait_valid(n);
    chk("ir6_cmd_ir", 64'(cmd_ir3), 64'd6);
    chk("ir6_valid", 64'(cmd_valid3), 64'd1);
    tick();
    chk("ir6_done", 64'(cmd_valid3), 64'd0);
    chk("ir6_pulses", 64'({ta3, tn3}), 64'd0);
    chk("ir6_low2_act", 64'(take_action), 64'(exp_pulse(m_ir3[1:0], v, 1'b1)));
    tick();
    chk("ir6_pulses_after", 64'({ta3, tn3}), 64'd0);
    vs_udr = 1'b0;
    cmd_ready = 1'b0;
    repeat (6) tick();

    // Reset while holding discards the command.
    r = {$urandom(), $urandom()};
    sr = r[SR_W-1:0] | (SR_W'(1) << ACT_BIT);
    vs_udr = 1'b1;
    wait_valid(n);
    vs_udr = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    reset_n = 1'b1;
    m_ir3 = '0;
    cmd_ready = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      if (take_action != 0 || take_no_action != 0) pulses++;
    end
    chk("rst_no_pulse", 64'(pulses), 64'd0);
    chk("rst_state", 64'({cmd_valid, overrun}), 64'd0);
    chk("rst_jdo", 64'({jdo, cmd_ir}), 64'd0);
    cmd_ready = 1'b0;

`ifdef DBG_CMD_TIMEOUT_EN
    // Unaccepted command on the TIMEOUT_CYC=16 instance is dropped after 16 HOLD cycles.
    r = {$urandom(), $urandom()};
    sr = r[SR_W-1:0] | (SR_W'(1) << ACT_BIT);
    vs_udr = 1'b1;
    wait_valid(n);
    chk("to_valid", 64'(cmd_valid_t), 64'd1);
    held = 1;
    pulses = 0;
    for (int k = 0; k < 30 && cmd_valid_t; k++) begin
      tick();
      if (cmd_valid_t) held++;
      if (ta_t != 0 || tn_t != 0) pulses++;
    end
    tick();
    if (ta_t != 0 || tn_t != 0) pulses++;
    chk("to_held", 64'(held), 64'd16);
    chk("to_flag", 64'(timeout_t), 64'd1);
    chk("to_no_pulse", 64'(pulses), 64'd0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("to_clr", 64'(timeout_t), 64'd0);
    vs_udr = 1'b0;
    cmd_ready = 1'b1;
    repeat (6) tick();
    cmd_ready = 1'b0;
`else
    chk("timeout_off", 64'(timeout), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_dbg_sysclk_cmd_unit.md
Name: nios_dbg_sysclk_cmd_unit

Overview:
- Parametrised system-clock half of the Nios II JTAG debug slave.
- Synchronises the virtual-JTAG update strobes (UIR/UDR) from the TCK domain and latches IR and the scan register into jdo.
- Presents each scanned command to the CPU debug logic through a valid/ready handshake, then issues one-hot take_action / take_no_action pulses per IR code.
- Generalises the fixed 2-bit-IR / 38-bit-SR / hard-wired-pulse design to arbitrary IR width, SR width and action count, and adds backpressure with overrun detection.

Parameters:
- IR_W, 2, instruction register width.
- SR_W, 38, scan register / jdo width.
- N_ACT, 4, number of action channels; IR codes 0..N_ACT-1 are decoded, N_ACT <= 2**IR_W.
- ACT_BIT, 37, jdo bit selecting action (1) vs no-action (0).
- SYNC_STAGES, 2, synchroniser depth (>=2).
- TIMEOUT_CYC, 1024, handshake timeout in clk cycles; used only with DBG_CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  virtual IR from TCK domain; stable around vs_uir.
- sr  in  SR_W  TCK-domain scan register; stable while vs_udr is high.
- vs_uir  in  1  update-IR level from TCK domain (asynchronous).
- vs_udr  in  1  update-DR level from TCK domain (asynchronous).
- jdo  out  SR_W  latched scan data.
- cmd_ir  out  IR_W  IR associated with the current jdo.
- cmd_valid  out  1  command pending.
- cmd_ready  in  1  consumer accepts the command.
- take_action  out  N_ACT  one-cycle pulse, index = cmd_ir, jdo[ACT_BIT]=1.
- take_no_action  out  N_ACT  one-cycle pulse, index = cmd_ir, jdo[ACT_BIT]=0.
- overrun  out  1  sticky: a UDR arrived while a command was pending.
- overrun_clr  in  1  clears overrun.
- timeout  out  1  sticky timeout flag; tied 0 when the feature is off.

Behaviour:
- Reset:
  - All outputs are 0, including jdo and cmd_ir.
  - State is IDLE and the synchroniser chains are cleared.
- Sync:
  - Each strobe passes through SYNC_STAGES flops.
  - edge = synced & ~synced_d.
  - A strobe first sampled high at clk edge 0 produces its edge at edge SYNC_STAGES.
- UIR edge: ir_q <= ir_in. This happens in any state.
- States:
  - IDLE: on a UDR edge, jdo <= sr and cmd_ir <= ir_q, then go to HOLD. cmd_valid rises at edge SYNC_STAGES+1 after the strobe is first sampled.
  - HOLD: cmd_valid=1; jdo and cmd_ir are frozen. On cmd_valid & cmd_ready, pulse take_action[cmd_ir] or take_no_action[cmd_ir] for exactly the next cycle, registered, and return to IDLE.
  - A UDR edge and the handshake in the same cycle both happen: the command completes, and the new UDR counts as an overrun. There is no back-to-back capture.
- cmd_ir >= N_ACT: the handshake completes normally and no pulse is issued.
- Simultaneous UIR and UDR edges: the captured cmd_ir uses the old ir_q, and ir_q updates afterwards.
- UDR edge in HOLD: the new command is dropped, jdo is unchanged, and overrun <= 1.
- overrun_clr and an overrun event in the same cycle: set wins.
- Pulse vectors are at most one-hot; take_action and take_no_action are never both non-zero.
- Reset mid-HOLD: the pending command is discarded and no pulse is issued.

Optional Feature:
- DBG_CMD_TIMEOUT_EN defined:
  - An $clog2(TIMEOUT_CYC+1)-bit counter clears on HOLD entry and increments each HOLD cycle without ready.
  - When the count reaches TIMEOUT_CYC-1 without ready, the next edge drops the command, returns to IDLE, sets timeout sticky (cleared by overrun_clr) and issues no pulse.
- DBG_CMD_TIMEOUT_EN undefined: there is no counter, HOLD waits indefinitely, and timeout=0.

Decomposition:
- Package nios_dbg_pkg holds:
  - state enum {IDLE, HOLD};
  - IR code constants IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3;
  - the default SR_W and ACT_BIT.
- Sub-module nios_dbg_strobe_sync (SYNC_STAGES chain plus rising-edge detect) is instantiated twice, once for UIR and once for UDR.

Test Plan:
- Reset, then vs_uir with ir_in=2, then sr=38'h20_1234_5678 and vs_udr held high 8 cycles, with cmd_ready=1:
  - cmd_valid rises 3 cycles after vs_udr is first sampled, with jdo=38'h20_1234_5678 and cmd_ir=2.
  - take_action=4'b0100 for 1 cycle.
- Same sequence with sr[37]=0, ir=0, and cmd_ready held low 20 cycles then high:
  - cmd_valid stays high 20 cycles.
  - take_no_action=4'b0001 pulses once, the cycle after ready.
- Second UDR with sr=38'h0_0000_00AA while in HOLD:
  - overrun=1 and jdo is unchanged.
  - overrun_clr clears it; overrun_clr asserted on the same cycle as a fresh overrun leaves overrun=1.
- IR_W=3, N_ACT=4, ir=6, UDR, ready=1: the handshake completes and both pulse vectors stay 0.
- Assert reset_n=0 mid-HOLD, release, then cmd_ready=1: cmd_valid=0, jdo=0, and no pulse.
- With DBG_CMD_TIMEOUT_EN and TIMEOUT_CYC=16, ready held low: after 16 HOLD cycles cmd_valid=0, timeout=1, and no pulse.
